// File: rtl/rx_seq_pkg.sv
// Shared types and constants for the receive packet sequencer.
package rx_seq_pkg;

    localparam int HDR_BYTES = 2;
    localparam int AA_W      = 32;

    localparam logic [1:0] MODE_BLE_0 = 2'd0;
    localparam logic [1:0] MODE_154   = 2'd1;
    localparam logic [1:0] MODE_BLE_2 = 2'd2;
    localparam logic [1:0] MODE_BLE_3 = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SEARCH  = 3'd2,
        HEADER  = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    // Number of set bits in an access-address-wide word.
    function automatic logic [5:0] popcount_aa(input logic [AA_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < AA_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/aa_correlator.sv
// Sliding access-address correlator. Bits arrive LSB first and enter at
// the top of the window; match is combinational on the shifting strobe so
// the FSM can register pkt_start one cycle after the 32nd bit.
module aa_correlator
    import rx_seq_pkg::*;
#(
    parameter int MAX_ERR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            shift,
    input  logic            bit_in,
    input  logic [AA_W-1:0] access_addr,
    output logic            match
);

    // Only the newest 31 bits are stored; the incoming bit completes the window.
    logic [AA_W-2:0] hist;
    logic [AA_W-1:0] window;
    logic [5:0]      bit_cnt;
    logic            full;

    assign window = {bit_in, hist};
    assign full   = (bit_cnt >= 6'(AA_W - 1));
    assign match  = shift && full && (popcount_aa(window ^ access_addr) <= 6'(MAX_ERR));

    // Window history and saturating bit count, flushed whenever search is not active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            hist <= window[AA_W-1:1];
            if (bit_cnt != 6'(AA_W)) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/rx_packet_sequencer.sv
// Receive-side sequencer: latches demod mode, holds the datapath in reset
// between packets, finds the access address and deserializes a
// length-prefixed packet onto a valid/ready byte port.
//
// state   | meaning
// IDLE    | datapath in reset; latch mode when enabled
// ARM     | datapath released; discard ARM_BITS settling strobes
// SEARCH  | correlate incoming bits against access_addr, bounded by timeout
// HEADER  | collect two header bytes; second one is the payload length
// PAYLOAD | collect and emit the remaining length bytes
module rx_packet_sequencer
    import rx_seq_pkg::*;
#(
    parameter int MAX_ERR  = 1,
    parameter int ARM_BITS = 8,
    parameter int TO_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic [AA_W-1:0] access_addr,
    input  logic [TO_W-1:0] search_timeout,
    output logic [1:0]      select,
    output logic            dp_rst,
    input  logic            update,
    input  logic            bit_in,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            pkt_start,
    output logic            pkt_done,
    output logic            pkt_err
);

    localparam int ARM_W = (ARM_BITS > 1) ? $clog2(ARM_BITS) : 1;
    localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    state_t            state, state_next;
    logic              update_q;
    logic [ARM_W-1:0]  arm_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_inc;
    logic [2:0]        bit_cnt;
    logic [6:0]        byte_sr;
    logic [7:0]        byte_next;
    logic [HDR_W-1:0]  hdr_cnt;
    logic [7:0]        len_rem;

    logic strobe, in_rx, byte_done, accept, overflow, search_shift, aa_match;
    logic start_c, done_c, err_c, load_c;

    assign strobe       = update && !update_q;
    assign in_rx        = (state == HEADER) || (state == PAYLOAD);
    assign byte_next    = {bit_in, byte_sr};
    assign byte_done    = strobe && in_rx && (bit_cnt == 3'd7);
    assign accept       = byte_valid && byte_ready;
    assign overflow     = byte_done && byte_valid && !byte_ready;
    assign search_shift = strobe && (state == SEARCH);
    assign to_cnt_inc   = to_cnt + 1'b1;

    aa_correlator #(
        .MAX_ERR (MAX_ERR)
    ) u_corr (
        .clk         (clk),
        .rst         (rst),
        .clear       (state != SEARCH),
        .shift       (search_shift),
        .bit_in      (bit_in),
        .access_addr (access_addr),
        .match       (aa_match)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle event decode; enable low aborts silently from any state.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        load_c     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARM;
                end
                ARM: begin
                    if (strobe && (arm_cnt == ARM_W'(ARM_BITS - 1))) begin
                        state_next = SEARCH;
                    end
                end
                SEARCH: begin
                    if (aa_match) begin
                        start_c    = 1'b1;
                        state_next = HEADER;
                    end else if (search_shift && (search_timeout != '0)
                                 && (to_cnt_inc == search_timeout)) begin
                        err_c      = 1'b1;
                        state_next = IDLE;
                    end
                end
                HEADER: begin
                    if (overflow) begin
                        err_c      = 1'b1;
                        state_next = IDLE;
                    end else if (byte_done) begin
                        load_c = 1'b1;
                        if (hdr_cnt == HDR_W'(HDR_BYTES - 1)) begin
                            if (byte_next == 8'd0) begin
                                done_c     = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (overflow) begin
                        err_c      = 1'b1;
                        state_next = IDLE;
                    end else if (byte_done) begin
                        load_c = 1'b1;
                        if (len_rem == 8'd1) begin
                            done_c     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Edge detect, settle/timeout counters and byte deserializer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_q <= 1'b0;
            arm_cnt  <= '0;
            to_cnt   <= '0;
            bit_cnt  <= '0;
            byte_sr  <= '0;
            hdr_cnt  <= '0;
            len_rem  <= '0;
        end else begin
            update_q <= update;

            if (state != ARM) begin
                arm_cnt <= '0;
            end else if (strobe) begin
                arm_cnt <= arm_cnt + 1'b1;
            end

            if (state != SEARCH) begin
                to_cnt <= '0;
            end else if (search_shift) begin
                to_cnt <= to_cnt_inc;
            end

            if (!in_rx) begin
                bit_cnt <= '0;
                byte_sr <= '0;
            end else if (strobe) begin
                bit_cnt <= bit_cnt + 3'd1;
                byte_sr <= byte_next[7:1];
            end

            if (state != HEADER) begin
                hdr_cnt <= '0;
            end else if (byte_done) begin
                hdr_cnt <= hdr_cnt + 1'b1;
            end

            if ((state == HEADER) && byte_done && (hdr_cnt == HDR_W'(HDR_BYTES - 1))) begin
                len_rem <= byte_next;
            end else if ((state == PAYLOAD) && byte_done) begin
                len_rem <= len_rem - 8'd1;
            end
        end
    end

    // Registered outputs: mode latch, datapath reset, byte port and event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            select     <= 2'd0;
            dp_rst     <= 1'b0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            if ((state == IDLE) && enable) begin
                select <= mode;
            end
            dp_rst <= (state_next != IDLE);
            if (load_c) begin
                byte_out   <= byte_next;
                byte_valid <= 1'b1;
            end else if (accept) begin
                byte_valid <= 1'b0;
            end
            pkt_start <= start_c;
            pkt_done  <= done_c;
            pkt_err   <= err_c;
        end
    end

endmodule

// File: doc/rx_packet_sequencer.md
# rx_packet_sequencer

Receive-side controller for the SCuM demodulator chain (I/Q source -> Matched_Filter + Timing_Recovery_BLE). It selects and latches the demodulator mode, holds the datapath in reset between packets, and consumes the recovered bit stream on each timing-recovery strobe. It searches for a programmable 32-bit access address with bounded bit errors, then deserializes a length-prefixed packet into bytes over a valid/ready interface.

## Interface
- MAX_ERR, 1, maximum access-address bit mismatches accepted (0..3)
- ARM_BITS, 8, update strobes ignored after datapath reset release (filter settling)
- TO_W, 16, width of search timeout counter
- clk  in  1  system clock (16 MHz)
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  level; high = receive, low = abort to IDLE
- mode  in  2  requested demod mode (0,2,3 BLE sub-bands; 1 = 802.15.4)
- access_addr  in  32  address to match, transmitted LSB first
- search_timeout  in  TO_W  max strobes in SEARCH; 0 = unlimited
- select  out  2  mode to Matched_Filter / Timing_Recovery_BLE
- dp_rst  out  1  active-low datapath reset
- update  in  1  timing-recovery bit strobe (level, rising edge = new bit)
- bit_in  in  1  demodulated bit from Matched_Filter
- byte_out  out  8  received byte
- byte_valid  out  1  byte_out holds a byte
- byte_ready  in  1  consumer accepts byte
- pkt_start  out  1  one-cycle pulse: address matched
- pkt_done  out  1  one-cycle pulse: last byte loaded
- pkt_err  out  1  one-cycle pulse: overflow or timeout

## Operation
- Reset values: select=0, dp_rst=0, byte_out=0, byte_valid=0, all pulses 0, state IDLE.
- Strobe = update high this cycle and low previous cycle (internal update_q, reset 0). bit_in sampled in strobe cycle.
- IDLE: dp_rst=0. If enable: select<=mode, go ARM. select changes only on this transition.
- ARM: dp_rst=1; count ARM_BITS strobes, then SEARCH (shift register and timeout counter cleared).
- SEARCH: each strobe shifts bit_in into bit 31 of a 32-bit register (right shift). After >=32 bits, if popcount(reg ^ access_addr) <= MAX_ERR on the strobe: pkt_start, go HEADER. Timeout counter increments per strobe; reaching search_timeout (nonzero) -> pkt_err, IDLE.
- HEADER: collect 2 bytes LSB-first; both emitted on byte_out. Second byte = length L (0..255).
- PAYLOAD: collect L bytes, emit each. L=0 skips PAYLOAD. On loading final byte (header byte 2 if L=0): pkt_done, IDLE.
- Output register: a completed byte loads byte_out, byte_valid=1. byte_valid clears on byte_valid&&byte_ready. If a byte completes while byte_valid=1 and byte_ready=0: overflow -> pkt_err, discard byte, IDLE; byte_valid and held byte unchanged. Completion and acceptance in same cycle -> new byte loaded, byte_valid stays 1, no error.
- enable low in any state: next cycle IDLE, no pulse; pending byte_valid held until accepted.
- Back-to-back: IDLE lasts exactly one cycle when enable remains high (dp_rst low one cycle).

## Timing
- Strobe-to-action: state change, pulses and byte load occur the cycle after the strobe cycle (registered).
- pkt_start, pkt_done, pkt_err: exactly one cycle, mutually exclusive.
- Address match latency: 1 cycle after 32nd matching bit's strobe.
- Strobes faster than 2 cycles apart are not supported (timing recovery guarantees >=4 at 16 MHz).

## Structure
- Package rx_seq_pkg: state enum (IDLE, ARM, SEARCH, HEADER, PAYLOAD), HDR_BYTES=2, AA_W=32, mode encoding constants.
- Sub-module aa_correlator: shift register, bit count, XOR-popcount, match output; cleared by FSM.
- Top: FSM, edge detect, bit/byte counters, output register. Target ~250 lines.

## Test plan
- AA=0x8E89BED6, MAX_ERR=1, stream 8 settle bits + AA + 0x02,0x03,0xA1,0xB2,0xC3, byte_ready=1 -> pkt_start once, bytes 02,03,A1,B2,C3, pkt_done with C3 load, select=mode.
- Same with one AA bit flipped -> match; two flipped (MAX_ERR=1) -> no pkt_start, search_timeout=100 -> pkt_err after 100th search strobe, IDLE.
- Length 0x00 -> bytes 02,00 only, pkt_done on 2nd byte.
- byte_ready=0 from first byte -> second byte completion gives pkt_err, byte_out stays 0x02 valid until ready.
- enable dropped mid-PAYLOAD -> IDLE next cycle, dp_rst=0, no pulse; rst asserted mid-packet -> all outputs to reset values immediately.
- mode changed during SEARCH -> select unchanged until next IDLE->ARM.
